// File: rtl/timer_multi.sv
// timer_multi: free-running 64-bit mtime with CHANNELS independent 64-bit
// compare registers and one registered level interrupt per channel.
// Word-addressed bus slave with byte write masks; combinational reads.
// Optional feature macro: TIMER_PRESCALER_EN builds the PRESCALE register and
// prescale counter; without it mtime advances every enabled cycle.
module timer_multi #(
   parameter int CHANNELS       = 2,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic [31:0]         address_in,
   input  logic                sel_in,
   input  logic                read_in,
   output logic [31:0]         read_value_out,
   input  logic [3:0]          write_mask_in,
   input  logic [31:0]         write_value_in,
   output logic [CHANNELS-1:0] timer_irq_out
);

   genvar gi;

   // Byte-wise replace of an existing word with the bus write data.
   function automatic logic [31:0] merge(input logic [31:0] old_word,
                                         input logic [31:0] new_word,
                                         input logic [31:0] mask);
      merge = (old_word & ~mask) | (new_word & mask);
   endfunction

   logic [5:0]  word_idx;
   logic [31:0] byte_mask;
   logic        any_wr;
   logic        wr_mtime_lo;
   logic        wr_mtime_hi;
   logic        wr_prescale;
   logic        wr_ctrl;
   logic        tick;
   logic        enable_reg;
   logic [63:0] mtime_reg;
   logic [63:0] mtime_next;
   logic [31:0] prescale_word;
   logic [31:0] read_word;
   logic [63:0] cmp_word [CHANNELS];
   logic        unused_bits;

   // Address bits outside the word index and the read strobe carry no meaning here.
   assign unused_bits = ^{read_in, address_in[31:8], address_in[1:0]};

   assign word_idx    = address_in[7:2];
   assign any_wr      = sel_in && (write_mask_in != 4'd0);
   assign wr_mtime_lo = any_wr && (word_idx == 6'd0);
   assign wr_mtime_hi = any_wr && (word_idx == 6'd1);
   assign wr_prescale = any_wr && (word_idx == 6'd2);
   assign wr_ctrl     = any_wr && (word_idx == 6'd3);

   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask
         assign byte_mask[8*gi +: 8] = {8{write_mask_in[gi]}};
      end
   endgenerate

`ifdef TIMER_PRESCALER_EN
   logic [PRESCALE_WIDTH-1:0] prescale_reg;
   logic [PRESCALE_WIDTH-1:0] prescale_next;
   logic [PRESCALE_WIDTH-1:0] pcount_reg;
   logic [PRESCALE_WIDTH-1:0] pcount_next;

   assign prescale_word = 32'(prescale_reg);
   assign tick          = enable_reg && (pcount_reg == prescale_reg);

   // Prescale divider: any mtime or PRESCALE write restarts the count from zero.
   always_comb begin
      prescale_next = prescale_reg;
      pcount_next   = pcount_reg;
      if (wr_prescale)
         prescale_next = PRESCALE_WIDTH'(merge(prescale_word, write_value_in, byte_mask));
      if (wr_mtime_lo || wr_mtime_hi || wr_prescale)
         pcount_next = '0;
      else if (tick)
         pcount_next = '0;
      else if (enable_reg)
         pcount_next = pcount_reg + PRESCALE_WIDTH'(1);
   end

   // Prescale state registers.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         prescale_reg <= '0;
         pcount_reg   <= '0;
      end else begin
         prescale_reg <= prescale_next;
         pcount_reg   <= pcount_next;
      end
   end
`else
   localparam int unused_prescale_width = PRESCALE_WIDTH;
   logic unused_prescale_wr;

   assign unused_prescale_wr = wr_prescale;
   assign prescale_word      = 32'd0;
   assign tick               = enable_reg;
`endif

   // mtime: a bus write to either half wins over the increment, with no carry between halves.
   always_comb begin
      mtime_next = mtime_reg;
      if (wr_mtime_lo || wr_mtime_hi) begin
         if (wr_mtime_lo)
            mtime_next[31:0] = merge(mtime_reg[31:0], write_value_in, byte_mask);
         if (wr_mtime_hi)
            mtime_next[63:32] = merge(mtime_reg[63:32], write_value_in, byte_mask);
      end else if (tick) begin
         mtime_next = mtime_reg + 64'd1;
      end
   end

   // mtime register.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         mtime_reg <= '0;
      else
         mtime_reg <= mtime_next;
   end

   // Count enable; the new value gates counting from the following cycle.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         enable_reg <= 1'b1;
      else if (wr_ctrl && write_mask_in[0])
         enable_reg <= write_value_in[0];
   end

   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [63:0] cmp_reg;
         logic [63:0] cmp_next;
         logic        irq_reg;
         logic        wr_lo;
         logic        wr_hi;

         assign wr_lo = any_wr && (word_idx == 6'(4 + 2*gi));
         assign wr_hi = any_wr && (word_idx == 6'(5 + 2*gi));

         // Byte-masked update of this channel's compare value.
         always_comb begin
            cmp_next = cmp_reg;
            if (wr_lo)
               cmp_next[31:0] = merge(cmp_reg[31:0], write_value_in, byte_mask);
            if (wr_hi)
               cmp_next[63:32] = merge(cmp_reg[63:32], write_value_in, byte_mask);
         end

         // Compare register and level interrupt from pre-edge mtime/compare values.
         always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
               cmp_reg <= '1;
               irq_reg <= 1'b0;
            end else begin
               cmp_reg <= cmp_next;
               irq_reg <= (mtime_reg >= cmp_reg);
            end
         end

         assign cmp_word[gi]      = cmp_reg;
         assign timer_irq_out[gi] = irq_reg;
      end
   endgenerate

   // Read mux over the word map; unmapped indices read zero.
   always_comb begin
      read_word = '0;
      case (word_idx)
         6'd0:    read_word = mtime_reg[31:0];
         6'd1:    read_word = mtime_reg[63:32];
         6'd2:    read_word = prescale_word;
         6'd3:    read_word = {31'd0, enable_reg};
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (word_idx == 6'(4 + 2*i))
                  read_word = cmp_word[i][31:0];
               if (word_idx == 6'(5 + 2*i))
                  read_word = cmp_word[i][63:32];
            end
         end
      endcase
   end

   assign read_value_out = sel_in ? read_word : 32'd0;

endmodule
